// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter for toggle-encoded requests that have already been synchronised into clk_b.
// A grant handshake is offered to one shared consumer, and completion is returned as a per-channel ack toggle.
//
// state | meaning
// IDLE  | no grant outstanding; waiting for any pending channel
// GRANT | gnt/gnt_valid offered, waiting for gnt_ready
// BUSY  | consumer owns the grant; waiting for done or hold timeout
// ACK   | one cycle: toggle ack, clear pending, advance pointer
module sync_req_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic               clk_b,
  input  logic               rst_b,
  input  logic [NUM_REQ-1:0] req_sync,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  input  logic               gnt_ready,
  input  logic               done,
  output logic [NUM_REQ-1:0] ack_tgl,
  output logic               busy,
  output logic               timeout,
  output logic               overrun
);

  localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t             state;
  logic [NUM_REQ-1:0] req_prev;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] req_edge;
  logic [NUM_REQ-1:0] clr_mask;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      sel;
  logic [IW-1:0]      pick;
  logic [IW-1:0]      ptr_nxt;
  logic               pick_found;
  logic [7:0]         hold_cnt;
  int                 cand;

  // An edge arriving in the same cycle that ACK clears the bit re-arms the channel without flagging an overrun.
  always_comb begin
    req_edge = req_sync ^ req_prev;
    clr_mask = '0;
    if (state == ACK) clr_mask[sel] = 1'b1;
  end

  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!pick_found && pending[cand]) begin
        pick       = IW'(cand);
        pick_found = 1'b1;
      end
    end
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
    ptr_nxt       = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);
  end

  always_ff @(posedge clk_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      req_prev  <= req_sync;
      pending   <= '0;
      ptr       <= '0;
      sel       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      ack_tgl   <= '0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      req_prev <= req_sync;
      pending  <= (pending & ~clr_mask) | req_edge;
      overrun  <= |(req_edge & pending & ~clr_mask);
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            sel       <= pick;
            gnt       <= pick_oh;
            gnt_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (gnt_ready) begin
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            gnt   <= '0;
            state <= ACK;
          end else if (hold_cnt == HOLD_LAST) begin
            gnt     <= '0;
            timeout <= 1'b1;
            state   <= ACK;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        ACK: begin
          ack_tgl <= ack_tgl ^ clr_mask;
          ptr     <= ptr_nxt;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Directed and randomized bench for sync_req_arbiter.
// The reference keeps the pending set, the rotation pointer and the expected ack levels as plain arrays.
module tb_sync_req_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 15;

  logic         clk_b = 1'b0;
  logic         rst_b;
  logic [N-1:0] req_sync;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         gnt_ready;
  logic         done;
  logic [N-1:0] ack_tgl;
  logic         busy;
  logic         timeout;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  bit [N-1:0] m_pend;
  bit [N-1:0] m_ack;
  int         m_ptr;

  sync_req_arbiter #(.NUM_REQ(N), .HOLD_MAX(HOLD)) dut (
    .clk_b     (clk_b),
    .rst_b     (rst_b),
    .req_sync  (req_sync),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .done      (done),
    .ack_tgl   (ack_tgl),
    .busy      (busy),
    .timeout   (timeout),
    .overrun   (overrun)
  );

  always #5 clk_b = ~clk_b;

  task automatic tick();
    @(posedge clk_b);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int c);
    logic [N-1:0] one;
    one = 1;
    return one << c;
  endfunction

  // The first pending channel, counting upward from the pointer and wrapping around.
  function automatic int pick(input bit [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++)
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_ack  = '0;
    m_ptr  = 0;
  endtask

  task automatic toggle(input logic [N-1:0] mask);
    req_sync = req_sync ^ mask;
    m_pend   = m_pend | mask;
  endtask

  task automatic expect_grant(output int ch);
    ch = pick(m_pend, m_ptr);
    tick();
    chk("grant_valid", gnt_valid, 1'b1);
    chk("grant_onehot", gnt, oh(ch));
  endtask

  task automatic serve(input int ch, input int rd, input int dd, input bit use_to, input bit retog);
    for (int i = 0; i < rd; i++) begin
      done = 1'($urandom_range(0, 1));
      tick();
      chk("hold_valid", gnt_valid, 1'b1);
      chk("hold_gnt", gnt, oh(ch));
    end
    done      = 1'b0;
    gnt_ready = 1'b1;
    tick();
    gnt_ready = 1'b0;
    chk("busy_entry", busy, 1'b1);
    chk("busy_valid", gnt_valid, 1'b0);
    chk("busy_gnt", gnt, oh(ch));
    if (use_to) begin
      for (int i = 0; i < HOLD - 1; i++) begin
        tick();
        chk("pre_timeout", timeout, 1'b0);
        chk("busy_hold_gnt", gnt, oh(ch));
      end
      tick();
      chk("timeout_pulse", timeout, 1'b1);
      chk("ack_gnt_zero", gnt, '0);
    end else begin
      for (int i = 0; i < dd; i++) begin
        tick();
        chk("busy_hold_gnt", gnt, oh(ch));
        chk("no_timeout", timeout, 1'b0);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("ack_gnt_zero", gnt, '0);
      chk("ack_busy", busy, 1'b1);
      chk("ack_no_timeout", timeout, 1'b0);
    end
    if (retog) req_sync[ch] = ~req_sync[ch];
    tick();
    m_ack[ch]  = ~m_ack[ch];
    m_pend[ch] = retog;
    m_ptr      = (ch + 1) % N;
    chk("ack_tgl", ack_tgl, m_ack);
    chk("idle_busy", busy, 1'b0);
    chk("idle_timeout", timeout, 1'b0);
    chk("idle_overrun", overrun, 1'b0);
    chk("idle_valid", gnt_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ch;
    int c;
    bit exp_ov;
    logic [N-1:0] mask;

    rst_b     = 1'b0;
    req_sync  = '1;
    gnt_ready = 1'b0;
    done      = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_gnt", gnt, '0);
    chk("rst_valid", gnt_valid, 1'b0);
    chk("rst_ack", ack_tgl, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("release_no_grant", gnt_valid, 1'b0);
      chk("release_idle", busy, 1'b0);
    end

    // Single request on channel 2, checking the two-cycle latency.
    toggle(4'b0100);
    tick();
    chk("lat_t1", gnt_valid, 1'b0);
    expect_grant(ch);
    chk("single_ch", ch, 2);
    serve(ch, 0, 2, 1'b0, 1'b0);

    // All four channels at once, with the pointer left at 3 so rotation starts at 3.
    toggle(4'b1111);
    tick();
    for (int g = 0; g < N; g++) begin
      expect_grant(ch);
      chk("rot_from3", ch, (3 + g) % N);
      serve(ch, 0, 1, 1'b0, 1'b0);
    end

    // Reset asserted while BUSY aborts the transaction.
    toggle(4'b0001);
    tick();
    expect_grant(ch);
    gnt_ready = 1'b1;
    tick();
    gnt_ready = 1'b0;
    chk("pre_abort_busy", busy, 1'b1);
    rst_b = 1'b0;
    tick();
    chk("abort_gnt", gnt, '0);
    chk("abort_valid", gnt_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ack", ack_tgl, '0);
    tick();
    rst_b = 1'b1;
    model_reset();
    tick();
    tick();
    chk("abort_no_regrant", gnt_valid, 1'b0);

    toggle(4'b1111);
    tick();
    for (int g = 0; g < N; g++) begin
      expect_grant(ch);
      chk("rot_from0", ch, g);
      serve(ch, 0, 1, 1'b0, 1'b0);
    end

    toggle(4'b0100);
    tick();
    expect_grant(ch);
    serve(ch, 10, 3, 1'b0, 1'b0);

    toggle(4'b1000);
    tick();
    expect_grant(ch);
    serve(ch, 0, 0, 1'b1, 1'b0);
    tick();
    chk("after_timeout_idle", busy, 1'b0);

    // Extra edges on channel 1 while its request is still pending.
    toggle(4'b0010);
    tick();
    chk("ov_first_edge", overrun, 1'b0);
    req_sync[1] = ~req_sync[1];
    tick();
    chk("ov_pulse1", overrun, 1'b1);
    chk("ov_gnt", gnt, 4'b0010);
    req_sync[1] = ~req_sync[1];
    tick();
    chk("ov_pulse2", overrun, 1'b1);
    tick();
    chk("ov_end", overrun, 1'b0);
    serve(1, 0, 1, 1'b0, 1'b0);
    tick();
    chk("ov_single_grant", gnt_valid, 1'b0);

    // A new edge arriving in the ACK cycle re-arms the same channel.
    toggle(4'b0001);
    tick();
    expect_grant(ch);
    serve(ch, 0, 0, 1'b0, 1'b1);
    expect_grant(ch);
    chk("rearm_ch", ch, 0);
    serve(ch, 1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      if (m_pend == '0) begin
        mask = N'($urandom_range(1, (1 << N) - 1));
        toggle(mask);
        tick();
        chk("rnd_lat_t1", gnt_valid, 1'b0);
      end
      expect_grant(ch);
      if ($urandom_range(0, 2) == 0) begin
        c      = $urandom_range(0, N - 1);
        exp_ov = m_pend[c];
        toggle(oh(c));
        tick();
        chk("rnd_overrun", overrun, exp_ov);
        chk("rnd_gnt_hold", gnt, oh(ch));
      end
      serve(ch, $urandom_range(0, 5), $urandom_range(0, 13),
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_req_arbiter.md
SYNC_REQ_ARBITER -- requirements
Module: sync_req_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requester channels (2..8).
REQ-002 The block SHALL have parameter HOLD_MAX, default 15, BUSY-state timeout in clk_b cycles (1..255).
REQ-003 The block SHALL have port clk_b  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_b  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port req_sync  input  NUM_REQ  per-channel request toggle levels, already synchronised into clk_b by two_stage_sync instances.
REQ-006 The block SHALL have port gnt  output  NUM_REQ  one-hot grant, all-zero when no grant.
REQ-007 The block SHALL have port gnt_valid  output  1  grant offered to the shared consumer.
REQ-008 The block SHALL have port gnt_ready  input  1  consumer accepts the offered grant.
REQ-009 The block SHALL have port done  input  1  consumer finished the granted transaction.
REQ-010 The block SHALL have port ack_tgl  output  NUM_REQ  per-channel completion toggle, returned to the source domain via two_stage_sync.
REQ-011 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 The block SHALL have port timeout  output  1  one-cycle pulse on BUSY timeout.
REQ-013 The block SHALL have port overrun  output  1  one-cycle pulse when a request edge hits an already-pending channel.

Function
REQ-014 Any change (rise or fall) of req_sync[i] versus registered req_prev[i] SHALL set pending[i] on the next edge.
REQ-015 An edge on a channel whose pending bit is already set SHALL leave pending set, merge the request and pulse overrun for one cycle.
REQ-016 If pending[i] is cleared and a new edge on channel i arrives in the same cycle, pending[i] SHALL end set; overrun SHALL NOT pulse.
REQ-017 The FSM SHALL have the states IDLE, GRANT, BUSY and ACK, encoded in 2 bits.
REQ-018 IDLE -> GRANT when pending is non-zero; sel = first pending index searched upward from ptr, wrapping modulo NUM_REQ.
REQ-019 In GRANT, gnt = one-hot(sel) and gnt_valid = 1; both SHALL hold stable until gnt_ready is high, then -> BUSY.
REQ-020 In BUSY, gnt SHALL stay asserted and gnt_valid = 0; done high -> ACK; done is ignored in every other state.
REQ-021 BUSY cycle counter: clears on entry to BUSY; if it reaches HOLD_MAX with done low, timeout pulses and the FSM -> ACK.
REQ-022 ACK lasts exactly one cycle and SHALL toggle ack_tgl[sel], clear pending[sel] and set ptr = (sel+1) mod NUM_REQ; gnt is 0, then -> IDLE.
REQ-023 Latency: req_sync change in cycle t -> pending in t+1 -> gnt_valid in t+2, given the FSM is in IDLE.
REQ-024 Fairness: with all channels continuously pending, grants SHALL rotate 0,1,...,NUM_REQ-1,0; no channel waits more than NUM_REQ-1 grants.
REQ-025 gnt_valid SHALL NOT be high without exactly one gnt bit set.

Reset
REQ-026 While rst_b = 0 at a clk_b edge, the block SHALL set state = IDLE, pending = 0, ptr = 0, counter = 0, gnt = 0, gnt_valid = 0, ack_tgl = 0, busy = 0, timeout = 0, overrun = 0.
REQ-027 During reset, req_prev SHALL load req_sync, so a high req_sync level at reset release produces no request.
REQ-028 Reset asserted mid-transaction (GRANT/BUSY/ACK) SHALL abort it with no ack_tgl toggle; outputs are at their reset values on the next edge.

Verification
REQ-029 Single request: req_sync[2] 0->1 at cycle t -> gnt = 0100 and gnt_valid = 1 at t+2; gnt_ready, then done -> ack_tgl[2] = 1 and ptr = 3.
REQ-030 All four channels toggle in the same cycle, consumer always ready, done one cycle after BUSY entry -> grant order 0,1,2,3 with each ack_tgl toggled once.
REQ-031 Consumer holds gnt_ready low for 10 cycles -> gnt and gnt_valid stay stable for the whole wait; BUSY is entered the cycle after gnt_ready rises.
REQ-032 done is never asserted, HOLD_MAX = 15 -> timeout pulses once after 15 BUSY cycles; ack_tgl toggles; FSM returns to IDLE.
REQ-033 Channel 1 toggles twice while its pending bit is set -> one overrun pulse per extra edge and a single grant for channel 1.
REQ-034 req_sync = 1111 during reset and rst_b released -> no grant; rst_b driven low during BUSY -> gnt = 0 and ack_tgl unchanged on the next edge.
